// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM encodings and bus payload types for the memory-access stage.
package mem_access_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OP_W       = 8;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BE_W       = 4;

  localparam logic [OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [OP_W-1:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [OP_W-1:0] EXE_SC_OP  = 8'b1111_1000;

  localparam logic Stop   = 1'b1;
  localparam logic Nostop = 1'b0;

  localparam int unsigned ADEL_BIT = 12;
  localparam int unsigned ADES_BIT = 13;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Bus request captured at issue so it stays stable while waiting for ack.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic mem_size_e op_size(input logic [OP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SZ_HALF;
      default:                          op_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data lane select with sign/zero extension (little-endian lanes).
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (op_i)
      EXE_LB_OP:  data_o = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: data_o = {24'd0, byte_sel};
      EXE_LH_OP:  data_o = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: data_o = {16'd0, half_sel};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: bus request/ack FSM, stall, alignment checks and LL/SC link.
// Optional LL/SC link bit enabled with macro MEM_LLSC_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [OP_W-1:0]       op_i,
  input  logic [DATA_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     sdata_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  wena_i,
  input  logic [DATA_W-1:0]     except_i,
  output logic                  d_req,
  output logic                  d_we,
  output logic [ADDR_W-1:0]     d_addr,
  output logic [BE_W-1:0]       d_be,
  output logic [DATA_W-1:0]     d_wdata,
  input  logic                  d_ack,
  input  logic [DATA_W-1:0]     d_rdata,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  wena_o,
  output logic [DATA_W-1:0]     except_o,
  output logic                  stall_req
);

  logic [1:0]        state_q, state_d;
  bus_req_t          req_q, req_d, new_req;
  logic [DATA_W-1:0] data_q, data_d;
  logic              link;
  logic              capture;

  mem_size_e         sz;
  logic              is_load, is_store, is_mem, is_sc;
  logic              misaligned, adel, ades, ok, sc_fail, issue;
  logic [OP_W-1:0]   align_op;
  logic [1:0]        align_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] cap_data;

  // Decode of the op currently held in ex_mem.
  always_comb begin
    sz         = op_size(op_i);
    is_load    = op_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
    is_store   = op_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP};
    is_mem     = is_load | is_store;
    is_sc      = (op_i == EXE_SC_OP);
    misaligned = is_mem && (((sz == SZ_HALF) && addr_i[0]) ||
                            ((sz == SZ_WORD) && (addr_i[1:0] != 2'b00)));
    adel       = is_load & misaligned;
    ades       = is_store & misaligned;
    ok         = is_mem & ~misaligned & (except_i == '0) & ~flush;
    sc_fail    = ok & is_sc & ~link;
    issue      = ok & ~sc_fail;
  end

  // Bus payload for a fresh issue from IDLE.
  always_comb begin
    new_req       = '0;
    new_req.op    = op_i;
    new_req.addr  = {addr_i[DATA_W-1:2], 2'b00};
    new_req.we    = is_store;
    case (sz)
      SZ_BYTE: begin
        new_req.be    = BE_W'(4'b0001 << addr_i[1:0]);
        new_req.wdata = {4{sdata_i[7:0]}};
      end
      SZ_HALF: begin
        new_req.be    = addr_i[1] ? 4'b1100 : 4'b0011;
        new_req.wdata = {2{sdata_i[15:0]}};
      end
      default: begin
        new_req.be    = 4'b1111;
        new_req.wdata = sdata_i;
      end
    endcase
    if (!is_store) new_req.wdata = '0;
  end

  // In IDLE the ack arrives for the op on the inputs; later it is for the captured op.
  assign align_op   = (state_q == ST_IDLE) ? op_i : req_q.op;
  assign align_addr = (state_q == ST_IDLE) ? addr_i[1:0] : req_q.addr[1:0];

  mem_load_align u_align (
    .op_i   (align_op),
    .addr_i (align_addr),
    .rdata_i(d_rdata),
    .data_o (ld_data)
  );

  assign cap_data = (align_op == EXE_SC_OP) ? DATA_W'(1) : ld_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

`ifdef MEM_LLSC_EN
  logic link_q, link_d;

  // Flush wins; an SC consumes the link whether or not it succeeds.
  always_comb begin
    link_d = link_q;
    if (flush)
      link_d = 1'b0;
    else if ((state_q == ST_IDLE) && ok && is_sc)
      link_d = 1'b0;
    else if (capture && (align_op == EXE_LL_OP))
      link_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) link_q <= 1'b0;
    else     link_q <= link_d;
  end

  assign link = link_q;
`else
  assign link = 1'b0;
`endif

  // Next state and all stage outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    capture   = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_be      = '0;
    d_wdata   = '0;
    stall_req = Nostop;
    waddr_o   = waddr_i;
    wdata_o   = wdata_i;
    wena_o    = wena_i & ~is_mem & ~flush;
    except_o  = except_i;
    except_o[ADEL_BIT] = except_i[ADEL_BIT] | adel;
    except_o[ADES_BIT] = except_i[ADES_BIT] | ades;
    if (sc_fail) begin
      wena_o  = 1'b1;
      wdata_o = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          d_req     = 1'b1;
          d_we      = new_req.we;
          d_addr    = ADDR_W'(new_req.addr);
          d_be      = new_req.be;
          d_wdata   = new_req.wdata;
          stall_req = Stop;
          req_d     = new_req;
          if (d_ack) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        d_req   = 1'b1;
        d_we    = req_q.we;
        d_addr  = ADDR_W'(req_q.addr);
        d_be    = req_q.be;
        d_wdata = req_q.wdata;
        wena_o  = 1'b0;
        if (flush) begin
          state_d = d_ack ? ST_IDLE : ST_DRAIN;
        end else begin
          stall_req = Stop;
          if (d_ack) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        wena_o  = ~flush & ((req_q.op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                                              EXE_LW_OP, EXE_LL_OP}) || (req_q.op == EXE_SC_OP));
        wdata_o = data_q;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // Finish the abandoned transfer; a new memory op waits stalled behind it.
        d_req     = 1'b1;
        d_we      = req_q.we;
        d_addr    = ADDR_W'(req_q.addr);
        d_be      = req_q.be;
        d_wdata   = req_q.wdata;
        stall_req = issue ? Stop : Nostop;
        if (d_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) data_d = cap_data;

    if (rst) begin
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_be      = '0;
      d_wdata   = '0;
      stall_req = Nostop;
      waddr_o   = '0;
      wdata_o   = '0;
      wena_o    = 1'b0;
      except_o  = '0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: loads/stores, alignment, flush/drain, LL/SC, reset.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  op_i;
  logic [31:0] addr_i, sdata_i, wdata_i, except_i, d_rdata;
  logic [4:0]  waddr_i;
  logic        wena_i, d_ack;
  logic        d_req, d_we, wena_o, stall_req;
  logic [31:0] d_addr, d_wdata, wdata_o, except_o;
  logic [3:0]  d_be;
  logic [4:0]  waddr_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] bdata;
    int          stall;
    logic        wena;
    logic [31:0] wdata;
    logic [31:0] exc;
  } rec_t;

  rec_t exp_q[$];

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_i(op_i), .addr_i(addr_i), .sdata_i(sdata_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .wena_i(wena_i), .except_i(except_i),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .wena_o(wena_o), .except_o(except_o), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  function automatic rec_t mk(bit req, logic [31:0] addr, logic [3:0] be, logic we,
                              logic [31:0] bdata, int stall, logic wena, logic [31:0] wdata,
                              logic [31:0] exc);
    rec_t r;
    r.req = req; r.addr = addr; r.be = be; r.we = we; r.bdata = bdata;
    r.stall = stall; r.wena = wena; r.wdata = wdata; r.exc = exc;
    return r;
  endfunction

  // Drives one op, acks after 'delay' wait cycles, then scores against the queued expectation.
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] exc, input int delay,
                        input logic [31:0] rdata);
    rec_t o, e;
    int   waits;
    bit   unstable, done;
    o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waits = 0; unstable = 0; done = 0;
    @(negedge clk);
    op_i = op; addr_i = addr; sdata_i = sdata; except_i = exc;
    waddr_i = 5'd9; wdata_i = 32'h5A5A_0000; wena_i = 1'b1; d_rdata = rdata; flush = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      d_ack = 1'b0;
      #1;
      if (d_req) begin
        if (!o.req) begin
          o.req = 1; o.addr = d_addr; o.be = d_be; o.we = d_we; o.bdata = d_wdata;
        end else if (d_addr !== o.addr || d_be !== o.be || d_we !== o.we || d_wdata !== o.bdata) begin
          unstable = 1;
        end
        if (waits == delay) d_ack = 1'b1;
        else waits++;
      end
      #1;
      if (stall_req) o.stall++;
      else begin
        o.wena = wena_o; o.wdata = wdata_o; o.exc = except_o; done = 1;
        break;
      end
    end
    d_ack = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout: stall never dropped (required write-back)", name); end
    checks++;
    if (o.req != e.req) begin errors++; $display("FAIL %s req: got %0d required %0d", name, o.req, e.req); end
    if (e.req && o.req) begin
      checks++;
      if (o.addr !== e.addr) begin errors++; $display("FAIL %s d_addr: got %h required %h", name, o.addr, e.addr); end
      checks++;
      if (o.be !== e.be) begin errors++; $display("FAIL %s d_be: got %b required %b", name, o.be, e.be); end
      checks++;
      if (o.we !== e.we) begin errors++; $display("FAIL %s d_we: got %b required %b", name, o.we, e.we); end
      checks++;
      if (o.bdata !== e.bdata) begin errors++; $display("FAIL %s d_wdata: got %h required %h", name, o.bdata, e.bdata); end
      checks++;
      if (unstable) begin errors++; $display("FAIL %s bus_stable: got changing bus required stable", name); end
    end
    checks++;
    if (o.stall != e.stall) begin errors++; $display("FAIL %s stall_cycles: got %0d required %0d", name, o.stall, e.stall); end
    checks++;
    if (o.wena !== e.wena) begin errors++; $display("FAIL %s wena_o: got %b required %b", name, o.wena, e.wena); end
    if (e.wena) begin
      checks++;
      if (o.wdata !== e.wdata) begin errors++; $display("FAIL %s wdata_o: got %h required %h", name, o.wdata, e.wdata); end
    end
    checks++;
    if (o.exc !== e.exc) begin errors++; $display("FAIL %s except_o: got %h required %h", name, o.exc, e.exc); end
  endtask

  task automatic set_nop(input logic we);
    op_i = EXE_NOP_OP; addr_i = 0; sdata_i = 0; except_i = 0;
    waddr_i = 5'd3; wdata_i = 32'h0000_0033; wena_i = we; d_ack = 0; flush = 0;
  endtask

  task automatic flush_cycle(input string name);
    @(negedge clk);
    set_nop(1'b1);
    flush = 1'b1;
    #1;
    checks++;
    if (d_req !== 1'b0 || wena_o !== 1'b0) begin
      errors++; $display("FAIL %s flush_idle: got req=%b wena=%b required 0/0", name, d_req, wena_o);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({d_req, stall_req, wena_o, d_we} !== 4'b0 || d_be !== 4'b0 || wdata_o !== 32'd0 || except_o !== 32'd0 || d_addr !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got req=%b stall=%b wena=%b be=%b required all zero", d_req, stall_req, wena_o, d_be);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    exp_q.push_back(mk(1, 32'h100, 4'b1000, 0, 0, 1, 1, 32'hFFFF_FF80, 0));
    run_op("lb_103", EXE_LB_OP, 32'h103, 0, 0, 0, 32'h80FF_1234);
    exp_q.push_back(mk(1, 32'h100, 4'b1000, 0, 0, 1, 1, 32'h0000_0080, 0));
    run_op("lbu_103", EXE_LBU_OP, 32'h103, 0, 0, 0, 32'h80FF_1234);
    exp_q.push_back(mk(1, 32'h100, 4'b1100, 0, 0, 1, 1, 32'hFFFF_80FF, 0));
    run_op("lh_102", EXE_LH_OP, 32'h102, 0, 0, 0, 32'h80FF_1234);
    exp_q.push_back(mk(1, 32'h100, 4'b0011, 0, 0, 1, 1, 32'h0000_1234, 0));
    run_op("lhu_100", EXE_LHU_OP, 32'h100, 0, 0, 0, 32'h80FF_1234);
    exp_q.push_back(mk(1, 32'h100, 4'b0010, 0, 0, 1, 1, 32'h0000_0012, 0));
    run_op("lbu_101", EXE_LBU_OP, 32'h101, 0, 0, 0, 32'h80FF_1234);
    exp_q.push_back(mk(1, 32'h104, 4'b1111, 0, 0, 3, 1, 32'hCAFE_F00D, 0));
    run_op("lw_104_wait2", EXE_LW_OP, 32'h104, 0, 0, 2, 32'hCAFE_F00D);
  endtask

  task automatic test_stores();
    exp_q.push_back(mk(1, 32'h200, 4'b1100, 1, 32'hBEEF_BEEF, 4, 0, 0, 0));
    run_op("sh_202_wait3", EXE_SH_OP, 32'h202, 32'h0000_BEEF, 0, 3, 0);
    exp_q.push_back(mk(1, 32'h200, 4'b0010, 1, 32'h7878_7878, 1, 0, 0, 0));
    run_op("sb_201", EXE_SB_OP, 32'h201, 32'h1234_5678, 0, 0, 0);
    exp_q.push_back(mk(1, 32'h204, 4'b1111, 1, 32'h1234_5678, 2, 0, 0, 0));
    run_op("sw_204_wait1", EXE_SW_OP, 32'h204, 32'h1234_5678, 0, 1, 0);
  endtask

  task automatic test_misaligned();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1000));
    run_op("lw_301", EXE_LW_OP, 32'h301, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_2000));
    run_op("sw_302", EXE_SW_OP, 32'h302, 32'h55, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1000));
    run_op("lh_105", EXE_LH_OP, 32'h105, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_2000));
    run_op("sh_203", EXE_SH_OP, 32'h203, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0400));
    run_op("lw_except_in", EXE_LW_OP, 32'h300, 0, 32'h0000_0400, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h5A5A_0000, 0));
    run_op("nop_pass", EXE_NOP_OP, 32'h300, 0, 0, 0, 0);
  endtask

  task automatic test_flush_idle();
    flush_cycle("flush_nop");
    @(negedge clk);
    op_i = EXE_LW_OP; addr_i = 32'h340; except_i = 0; wena_i = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (d_req !== 1'b0 || stall_req !== 1'b0 || wena_o !== 1'b0) begin
      errors++; $display("FAIL flush_lw_idle: got req=%b stall=%b wena=%b required 0/0/0", d_req, stall_req, wena_o);
    end
    @(negedge clk);
    set_nop(1'b0);
  endtask

  task automatic test_drain();
    @(negedge clk);
    op_i = EXE_LW_OP; addr_i = 32'h500; except_i = 0; waddr_i = 5'd4; wena_i = 1'b0; d_ack = 0;
    #1;
    checks++;
    if (d_req !== 1'b1 || stall_req !== 1'b1) begin
      errors++; $display("FAIL drain_issue: got req=%b stall=%b required 1/1", d_req, stall_req);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (d_req !== 1'b1 || stall_req !== 1'b0 || d_addr !== 32'h500) begin
      errors++; $display("FAIL drain_flush: got req=%b stall=%b addr=%h required 1/0/500", d_req, stall_req, d_addr);
    end
    @(negedge clk);
    set_nop(1'b1);
    #1;
    checks++;
    if (d_req !== 1'b1 || stall_req !== 1'b0 || d_addr !== 32'h500 || wena_o !== 1'b1 || wdata_o !== 32'h33) begin
      errors++; $display("FAIL drain_hold: got req=%b stall=%b addr=%h wena=%b required 1/0/500/1", d_req, stall_req, d_addr, wena_o);
    end
    @(negedge clk);
    op_i = EXE_LW_OP; addr_i = 32'h504; waddr_i = 5'd6; wena_i = 1'b0; d_rdata = 32'hDEAD_DEAD;
    #1;
    checks++;
    if (d_req !== 1'b1 || d_addr !== 32'h500 || stall_req !== 1'b1) begin
      errors++; $display("FAIL drain_wait: got req=%b addr=%h stall=%b required 1/500/1", d_req, d_addr, stall_req);
    end
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0; d_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if (d_req !== 1'b1 || d_addr !== 32'h504 || stall_req !== 1'b1) begin
      errors++; $display("FAIL drain_reissue: got req=%b addr=%h stall=%b required 1/504/1", d_req, d_addr, stall_req);
    end
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    #1;
    checks++;
    if (stall_req !== 1'b0 || wena_o !== 1'b1 || wdata_o !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL drain_wb: got stall=%b wena=%b wdata=%h required 0/1/0badf00d", stall_req, wena_o, wdata_o);
    end
    @(negedge clk);
    set_nop(1'b0);
  endtask

  task automatic test_flush_ack();
    @(negedge clk);
    op_i = EXE_LW_OP; addr_i = 32'h700; except_i = 0; wena_i = 1'b0; d_ack = 0; d_rdata = 32'h1111_1111;
    @(negedge clk);
    flush = 1'b1; d_ack = 1'b1;
    @(negedge clk);
    set_nop(1'b0);
    #1;
    checks++;
    if (d_req !== 1'b0 || wena_o !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL flush_ack_discard: got req=%b wena=%b stall=%b required 0/0/0", d_req, wena_o, stall_req);
    end
  endtask

  task automatic test_llsc();
`ifdef MEM_LLSC_EN
    exp_q.push_back(mk(1, 32'h400, 4'b1111, 0, 0, 1, 1, 32'h1111_2222, 0));
    run_op("ll_400", EXE_LL_OP, 32'h400, 0, 0, 0, 32'h1111_2222);
    exp_q.push_back(mk(1, 32'h400, 4'b1111, 1, 32'h0000_0077, 2, 1, 32'h1, 0));
    run_op("sc_400_ok", EXE_SC_OP, 32'h400, 32'h77, 0, 1, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
    run_op("sc_400_again", EXE_SC_OP, 32'h400, 32'h77, 0, 0, 0);
    exp_q.push_back(mk(1, 32'h400, 4'b1111, 0, 0, 1, 1, 32'h3333_4444, 0));
    run_op("ll_400_b", EXE_LL_OP, 32'h400, 0, 0, 0, 32'h3333_4444);
    flush_cycle("flush_link");
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
    run_op("sc_after_flush", EXE_SC_OP, 32'h400, 32'h77, 0, 0, 0);
`else
    exp_q.push_back(mk(1, 32'h400, 4'b1111, 0, 0, 1, 1, 32'h1111_2222, 0));
    run_op("ll_as_lw", EXE_LL_OP, 32'h400, 0, 0, 0, 32'h1111_2222);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
    run_op("sc_fails", EXE_SC_OP, 32'h400, 32'h77, 0, 0, 0);
`endif
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_2000));
    run_op("sc_misaligned", EXE_SC_OP, 32'h402, 32'h77, 0, 0, 0);
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    op_i = EXE_LW_OP; addr_i = 32'h600; except_i = 0; wena_i = 1'b1; d_ack = 0;
    @(negedge clk);
    #1;
    checks++;
    if (d_req !== 1'b1 || stall_req !== 1'b1) begin
      errors++; $display("FAIL rst_busy_pre: got req=%b stall=%b required 1/1", d_req, stall_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d_req !== 1'b0 || stall_req !== 1'b0 || wena_o !== 1'b0) begin
      errors++; $display("FAIL rst_async: got req=%b stall=%b wena=%b required 0/0/0", d_req, stall_req, wena_o);
    end
    @(negedge clk);
    set_nop(1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (d_req !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL rst_idle: got req=%b stall=%b required 0/0", d_req, stall_req);
    end
    exp_q.push_back(mk(1, 32'h604, 4'b1111, 0, 0, 1, 1, 32'h600D_600D, 0));
    run_op("lw_after_rst", EXE_LW_OP, 32'h604, 0, 0, 0, 32'h600D_600D);
  endtask

  initial begin
    rst = 1'b1;
    set_nop(1'b0);
    d_rdata = 0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_flush_idle();
    test_drain();
    test_flush_ack();
    test_llsc();
    test_reset_busy();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
